// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control path.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    RUNNING = 3'b001,
    LAP     = 3'b010,
    PAUSED  = 3'b011,
    HALTED  = 3'b100
  } sw_state_t;

  // 100 Hz board clock / 10 gives 0.1 s count resolution.
  localparam int TICK_DIV_DEFAULT = 10;

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Pushbutton conditioner: two-flop synchronizer followed by a rising-edge
// detector. Produces one single-cycle event per press; a held button does
// not repeat.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic ev
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Shift the raw level through the synchronizer and the prior-value flop.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchronizer and edge-history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign ev = sync2_q & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: start/stop and lap/reset state machine,
// count-tick prescaler, and the enable/clear/lap/freeze controls for the
// BCD counter and display datapath. Count saturates at full scale.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_btn,
  input  logic       lr_btn,
  input  logic       all_max,
  output logic [2:0] state,
  output logic       cnt_en,
  output logic       cnt_clear,
  output logic       lap_capture,
  output logic       freeze,
  output logic       running
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  sw_state_t     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          cnt_clear_q, cnt_clear_d;
  logic          lap_capture_q, lap_capture_d;

  logic ss_ev;
  logic lr_ev;
  logic active;
  logic tick;

  btn_edge u_ss_edge (
    .clk (clk),
    .rst (rst),
    .btn (ss_btn),
    .ev  (ss_ev)
  );

  btn_edge u_lr_edge (
    .clk (clk),
    .rst (rst),
    .btn (lr_btn),
    .ev  (lr_ev)
  );

  assign active = (state_q == RUNNING) || (state_q == LAP);
  assign tick   = active && (presc_q == PRESC_LAST);

  // Next state and one-shot pulses; start/stop wins over lap/reset, and any
  // button event wins over saturating into HALTED.
  always_comb begin
    state_d       = state_q;
    cnt_clear_d   = 1'b0;
    lap_capture_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_ev) state_d = RUNNING;
      end
      RUNNING: begin
        if (ss_ev) begin
          state_d = PAUSED;
        end else if (lr_ev) begin
          state_d       = LAP;
          lap_capture_d = 1'b1;
        end else if (tick && all_max) begin
          state_d = HALTED;
        end
      end
      LAP: begin
        if (ss_ev) begin
          state_d = PAUSED;
        end else if (lr_ev) begin
          state_d = RUNNING;
        end else if (tick && all_max) begin
          state_d = HALTED;
        end
      end
      PAUSED: begin
        if (ss_ev) begin
          state_d = RUNNING;
        end else if (lr_ev) begin
          state_d     = IDLE;
          cnt_clear_d = 1'b1;
        end
      end
      HALTED: begin
        if (lr_ev) begin
          state_d     = IDLE;
          cnt_clear_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Prescaler: advances only while counting, holds otherwise so a paused
  // partial tick is kept, and is zeroed whenever IDLE is (or becomes) current.
  always_comb begin
    presc_d = presc_q;
    if (active) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
    if (state_d == IDLE) begin
      presc_d = '0;
    end
  end

  // State, prescaler and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      presc_q       <= '0;
      cnt_clear_q   <= 1'b0;
      lap_capture_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      cnt_clear_q   <= cnt_clear_d;
      lap_capture_q <= lap_capture_d;
    end
  end

  assign state       = state_q;
  assign cnt_en      = tick & ~all_max;
  assign cnt_clear   = cnt_clear_q;
  assign lap_capture = lap_capture_q;
  assign freeze      = (state_q == LAP);
  assign running     = active;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with a cycle-level reference model.
module tb_stopwatch_ctrl;

  localparam int TD = 10;
  localparam logic [2:0] E_IDLE = 3'd0;
  localparam logic [2:0] E_RUN  = 3'd1;
  localparam logic [2:0] E_LAP  = 3'd2;
  localparam logic [2:0] E_PAU  = 3'd3;
  localparam logic [2:0] E_HALT = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss_btn;
  logic       lr_btn;
  logic       all_max;
  logic [2:0] state;
  logic       cnt_en;
  logic       cnt_clear;
  logic       lap_capture;
  logic       freeze;
  logic       running;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk         (clk),
    .rst         (rst),
    .ss_btn      (ss_btn),
    .lr_btn      (lr_btn),
    .all_max     (all_max),
    .state       (state),
    .cnt_en      (cnt_en),
    .cnt_clear   (cnt_clear),
    .lap_capture (lap_capture),
    .freeze      (freeze),
    .running     (running)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: stopwatch state, cycles spent counting since the last
  // return to IDLE, pending one-cycle pulses, and raw-button sample history
  // (index 0 = sampled at the most recent edge).
  logic [2:0] m_state;
  int         m_run;
  bit         m_clear;
  bit         m_lap;
  bit [2:0]   ss_hist;
  bit [2:0]   lr_hist;

  function automatic logic [7:0] dut_vec();
    return {state, cnt_en, cnt_clear, lap_capture, freeze, running};
  endfunction

  function automatic logic [7:0] mdl_vec();
    bit run  = (m_state == E_RUN) || (m_state == E_LAP);
    bit tk   = run && ((m_run % TD) == TD - 1);
    return {m_state, tk && !all_max, m_clear, m_lap, m_state == E_LAP, run};
  endfunction

  task automatic mdl_reset();
    m_state = E_IDLE;
    m_run   = 0;
    m_clear = 0;
    m_lap   = 0;
    ss_hist = '0;
    lr_hist = '0;
  endtask

  // A press sampled at edge N is acted upon at edge N+2.
  task automatic mdl_step();
    bit         sse = ss_hist[1] & ~ss_hist[2];
    bit         lre = lr_hist[1] & ~lr_hist[2];
    bit         run = (m_state == E_RUN) || (m_state == E_LAP);
    bit         tk  = run && ((m_run % TD) == TD - 1);
    logic [2:0] nx  = m_state;
    bit         nc  = 0;
    bit         nl  = 0;
    case (m_state)
      E_IDLE: if (sse) nx = E_RUN;
      E_RUN: begin
        if (sse) nx = E_PAU;
        else if (lre) begin nx = E_LAP; nl = 1; end
        else if (tk && all_max) nx = E_HALT;
      end
      E_LAP: begin
        if (sse) nx = E_PAU;
        else if (lre) nx = E_RUN;
        else if (tk && all_max) nx = E_HALT;
      end
      E_PAU: begin
        if (sse) nx = E_RUN;
        else if (lre) begin nx = E_IDLE; nc = 1; end
      end
      E_HALT: if (lre) begin nx = E_IDLE; nc = 1; end
      default: nx = E_IDLE;
    endcase
    if (run) m_run++;
    if (nx == E_IDLE) m_run = 0;
    m_state = nx;
    m_clear = nc;
    m_lap   = nl;
    ss_hist = {ss_hist[1:0], ss_btn};
    lr_hist = {lr_hist[1:0], lr_btn};
  endtask

  // Apply inputs at the falling edge, advance one rising edge, return at the
  // next falling edge with the model updated.
  task automatic tick_cycle(input bit ss, input bit lr, input bit am);
    ss_btn  = ss;
    lr_btn  = lr;
    all_max = am;
    @(posedge clk);
    mdl_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ss_btn = 1'b0; lr_btn = 1'b0; all_max = 1'b0;
    mdl_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if (dut_vec() !== 8'h00) begin
      n_fail++; $display("FAIL reset_hold: got %b expected %b", dut_vec(), 8'h00);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick_cycle(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (dut_vec() !== mdl_vec() || state !== E_IDLE) begin
        n_fail++; $display("FAIL reset_idle: got %b expected %b", dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_start();
    tick_cycle(1'b1, 1'b0, 1'b0);
    tick_cycle(1'b1, 1'b0, 1'b0);
    n_chk++;
    if (state !== E_IDLE) begin
      n_fail++; $display("FAIL start_early: got state %0d expected %0d", state, E_IDLE);
    end
    tick_cycle(1'b0, 1'b0, 1'b0);
    n_chk++;
    if (state !== E_RUN || running !== 1'b1) begin
      n_fail++; $display("FAIL start_state: got state %0d running %b expected %0d 1", state, running, E_RUN);
    end
    for (int i = 1; i <= 3 * TD; i++) begin
      tick_cycle(1'b0, 1'b0, 1'b0);
      n_chk++;
      if (dut_vec() !== mdl_vec() || cnt_en !== ((i % TD) == TD - 1)) begin
        n_fail++; $display("FAIL start_cadence@%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_lap();
    int caps = 0;
    for (int i = 0; i < 2 * TD; i++) begin
      tick_cycle(1'b0, i < 3, 1'b0);
      caps += int'(lap_capture);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL lap_enter@%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
    n_chk++;
    if (caps != 1 || state !== E_LAP || freeze !== 1'b1) begin
      n_fail++; $display("FAIL lap_capture: got caps %0d state %0d freeze %b expected 1 %0d 1", caps, state, freeze, E_LAP);
    end
    for (int i = 0; i < TD; i++) begin
      tick_cycle(1'b0, i < 2, 1'b0);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL lap_exit@%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
    n_chk++;
    if (state !== E_RUN || freeze !== 1'b0) begin
      n_fail++; $display("FAIL lap_return: got state %0d freeze %b expected %0d 0", state, freeze, E_RUN);
    end
  endtask

  task automatic test_pause_resume();
    int ens = 0;
    for (int i = 0; i < 53; i++) begin
      tick_cycle(i < 2, 1'b0, 1'b0);
      if (state == E_PAU) ens += int'(cnt_en);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL pause@%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
    n_chk++;
    if (state !== E_PAU || ens != 0) begin
      n_fail++; $display("FAIL pause_hold: got state %0d cnt_en pulses %0d expected %0d 0", state, ens, E_PAU);
    end
    for (int i = 0; i < 2 * TD; i++) begin
      tick_cycle(i < 2, 1'b0, 1'b0);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL resume@%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_clear();
    int clrs = 0;
    for (int i = 0; i < 6; i++) tick_cycle(i < 2, 1'b0, 1'b0);
    n_chk++;
    if (state !== E_PAU) begin
      n_fail++; $display("FAIL clear_setup: got state %0d expected %0d", state, E_PAU);
    end
    for (int i = 0; i < 8; i++) begin
      tick_cycle(1'b0, i < 2, 1'b0);
      clrs += int'(cnt_clear);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL clear@%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
    n_chk++;
    if (clrs != 1 || state !== E_IDLE || dut.presc_q !== '0) begin
      n_fail++; $display("FAIL clear_pulse: got pulses %0d state %0d presc %0d expected 1 %0d 0", clrs, state, dut.presc_q, E_IDLE);
    end
    for (int i = 0; i < 8; i++) begin
      tick_cycle(1'b0, i < 2, 1'b0);
      n_chk++;
      if (dut_vec() !== 8'h00) begin
        n_fail++; $display("FAIL idle_lr@%0d: got %b expected %b", i, dut_vec(), 8'h00);
      end
    end
  endtask

  task automatic test_halt();
    int  ens = 0;
    bit  hit = 0;
    for (int i = 0; i < 6; i++) tick_cycle(i < 2, 1'b0, 1'b0);
    for (int i = 0; i < 3 * TD && !hit; i++) begin
      tick_cycle(1'b0, 1'b0, 1'b1);
      ens += int'(cnt_en);
      hit = (state == E_HALT);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL halt_run@%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
    n_chk++;
    if (!hit || ens != 0) begin
      n_fail++; $display("FAIL halt_reach: got halted %b cnt_en pulses %0d expected 1 0", hit, ens);
    end
    for (int i = 0; i < 8; i++) tick_cycle(i < 2, 1'b0, 1'b1);
    n_chk++;
    if (state !== E_HALT || running !== 1'b0) begin
      n_fail++; $display("FAIL halt_ss: got state %0d running %b expected %0d 0", state, running, E_HALT);
    end
    for (int i = 0; i < 6; i++) begin
      tick_cycle(1'b0, i < 2, 1'b0);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL halt_lr@%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_simul_and_rst();
    int caps = 0;
    for (int i = 0; i < 8; i++) tick_cycle(i < 2, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick_cycle(i < 2, i < 2, 1'b0);
      caps += int'(lap_capture);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL simul@%0d: got %b expected %b", i, dut_vec(), mdl_vec());
      end
    end
    n_chk++;
    if (state !== E_PAU || caps != 0) begin
      n_fail++; $display("FAIL simul_prio: got state %0d caps %0d expected %0d 0", state, caps, E_PAU);
    end
    for (int i = 0; i < 6; i++) tick_cycle(i < 2, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick_cycle(1'b0, i < 2, 1'b0);
    n_chk++;
    if (state !== E_LAP || dut_vec() !== mdl_vec()) begin
      n_fail++; $display("FAIL rst_setup: got %b expected %b", dut_vec(), mdl_vec());
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (dut_vec() !== 8'h00) begin
      n_fail++; $display("FAIL rst_async: got %b expected %b", dut_vec(), 8'h00);
    end
    mdl_reset();
    @(negedge clk);
    rst = 1'b0;
    tick_cycle(1'b0, 1'b0, 1'b0);
    n_chk++;
    if (dut_vec() !== 8'h00) begin
      n_fail++; $display("FAIL rst_release: got %b expected %b", dut_vec(), 8'h00);
    end
  endtask

  task automatic test_random();
    bit am = 0;
    for (int seg = 0; seg < 400; seg++) begin
      bit s    = ($urandom_range(0, 3) == 0);
      bit l    = ($urandom_range(0, 3) == 0);
      int hold = $urandom_range(1, 8);
      if ($urandom_range(0, 15) == 0) am = ~am;
      for (int i = 0; i < hold; i++) begin
        tick_cycle(s, l, am);
        n_chk++;
        if (dut_vec() !== mdl_vec()) begin
          n_fail++; $display("FAIL random@%0d: got %b expected %b", seg, dut_vec(), mdl_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_lap();
    test_pause_resume();
    test_clear();
    test_halt();
    test_simul_and_rst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch datapath. It turns two raw pushbuttons into a standard start/stop and lap/reset stopwatch state machine. It divides the board clock into count ticks and drives the enable and clear of the downstream cascaded BCD digit counters, plus lap-capture and display-freeze for the display path. It saturates the count at full scale instead of wrapping.

## Interface
- TICK_DIV, 10, clk cycles per count tick (≥2); 10 at hz100 gives 0.1 s resolution
- clk  in  1  system clock (hz100)
- rst  in  1  reset, asynchronous, active-high
- ss_btn  in  1  raw start/stop button, asynchronous to clk, level
- lr_btn  in  1  raw lap/reset button, asynchronous to clk, level
- all_max  in  1  from datapath: every digit counter is at its max (full scale)
- state  out  3  current sw_state_t
- cnt_en  out  1  one-cycle count-increment pulse to the least-significant digit counter
- cnt_clear  out  1  one-cycle synchronous clear to all digit counters
- lap_capture  out  1  one-cycle pulse: display register loads the current count
- freeze  out  1  level: display shows the lap register, not the live count
- running  out  1  level: state is RUNNING or LAP (LED)

## Operation
- Each button passes through 2-FF sync, then a prior-value flop. The rising-edge pulse (ss_ev / lr_ev) lasts one cycle per press. Held buttons do not repeat.
- States: IDLE, RUNNING, LAP, PAUSED, HALTED. Transitions are evaluated each clk edge. If ss_ev and lr_ev occur in the same cycle, ss_ev is processed and lr_ev is dropped.
- IDLE: ss_ev → RUNNING. lr_ev is ignored.
- RUNNING: ss_ev → PAUSED. lr_ev → LAP with lap_capture.
- LAP: ss_ev → PAUSED, freeze drops. lr_ev → RUNNING, freeze drops.
- PAUSED: ss_ev → RUNNING. lr_ev → IDLE with cnt_clear.
- HALTED: ss_ev is ignored. lr_ev → IDLE with cnt_clear.
- RUNNING or LAP with tick and all_max=1 → HALTED. If a button event coincides with this, the button event has priority.
- Prescaler `presc` is `$clog2(TICK_DIV)` bits wide:
  - counts 0..TICK_DIV-1 and wraps, only in RUNNING/LAP;
  - holds its value in PAUSED and HALTED;
  - is forced to 0 in IDLE and on every entry to IDLE.
- tick = (state ∈ {RUNNING, LAP}) & (presc == TICK_DIV-1).
- cnt_en = tick & ~all_max. It is combinational from registered state/presc and is never asserted outside RUNNING/LAP.
- cnt_clear and lap_capture are registered. Each is high for exactly the first cycle of the destination state.
- freeze = (state == LAP). running = (state ∈ {RUNNING, LAP}).
- Any undefined state encoding recovers to IDLE on the next edge.

## Timing
- Reset values: state=IDLE, presc=0, all sync/edge flops 0, cnt_en=0, cnt_clear=0, lap_capture=0, freeze=0, running=0.
- Button latency: a raw rise first sampled at edge N produces an event valid between N+1 and N+2. state, cnt_clear and lap_capture update at edge N+2.
- First cnt_en after entering RUNNING from IDLE occurs TICK_DIV cycles after the state change. cnt_en then repeats every TICK_DIV cycles.
- Pause/resume: presc is retained, so the partial tick is preserved across PAUSED.
- Reset asserted mid-operation immediately returns all outputs to their reset values. No cnt_clear pulse is generated; the datapath has its own reset.

## Structure
- Shared package `stopwatch_pkg`:
  - `sw_state_t` (3-bit enum): IDLE=3'b000, RUNNING=3'b001, LAP=3'b010, PAUSED=3'b011, HALTED=3'b100.
  - The default TICK_DIV constant.
- One sub-module, `btn_edge`: sync + rising-edge detect, async reset. It is instantiated once for ss_btn and once for lr_btn.
- All other logic lives in stopwatch_ctrl: state register, next-state logic, prescaler, registered pulse outputs.

## Test plan
- Reset, then press ss at cycle 5 (TICK_DIV=10) → state=RUNNING at edge 7; cnt_en pulses at cycles 17, 27, 37…; running=1.
- Running, press lr → state=LAP, lap_capture high for exactly 1 cycle, freeze=1, cnt_en cadence unchanged; press lr again → RUNNING, freeze=0.
- Running with presc=4, press ss → PAUSED, no cnt_en; after 50 cycles press ss → RUNNING; next cnt_en comes 5 cycles after resume.
- PAUSED, press lr → IDLE, cnt_clear high for 1 cycle, presc=0; a further lr in IDLE → no change, no pulses.
- RUNNING, drive all_max=1 → at next tick cnt_en stays 0 and state=HALTED; ss is ignored; lr → IDLE with cnt_clear.
- Press ss and lr rising on the same cycle from RUNNING → PAUSED, no lap_capture; assert rst mid-LAP → all outputs 0, state=IDLE immediately.
